// File: rtl/soft_start_ramp_pwm.sv
// Soft-start / soft-stop motor ramp: tick prescaler, dwell counter, four-state
// duty ramp with fast/slow dwell modes, and a registered PWM comparator.
module soft_start_ramp_pwm #(
  parameter int WIDTH      = 8,
  parameter int DUTY_STEP  = 64,
  parameter int TICK_DIV   = 100000,
  parameter int DWELL_FAST = 2,
  parameter int DWELL_SLOW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rapido,
  input  logic             lento,
  output logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic [1:0]       state,
  output logic             running,
  output logic             at_full
);

  localparam int PW    = $clog2(TICK_DIV);
  localparam int DWMAX = (DWELL_FAST > DWELL_SLOW) ? DWELL_FAST : DWELL_SLOW;
  localparam int DW    = $clog2(DWMAX + 1);

  localparam logic [WIDTH-1:0] MAX          = '1;
  localparam logic [WIDTH:0]   STEP_EXT     = (WIDTH+1)'(DUTY_STEP);
  localparam logic [PW-1:0]    TICK_LAST    = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]    DW_FAST_LAST = DW'(DWELL_FAST - 1);
  localparam logic [DW-1:0]    DW_SLOW_LAST = DW'(DWELL_SLOW - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    FULL      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] s;
    s = {1'b0, a} + STEP_EXT;
    if (s > {1'b0, MAX}) return MAX;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] d;
    if ({1'b0, a} < STEP_EXT) return '0;
    d = {1'b0, a} - STEP_EXT;
    return d[WIDTH-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             fast_q, fast_d;
  logic             pwm_q, pwm_d;
  logic             run, tick, step;
  logic [DW-1:0]    dwell_last;

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    fast_d     = fast_q;
    run        = rapido | lento;
    tick       = (presc_q == TICK_LAST);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    dwell_last = fast_q ? DW_FAST_LAST : DW_SLOW_LAST;
    step       = tick && (dwell_q == dwell_last);
    dwell_d    = step ? '0 : (tick ? dwell_q + 1'b1 : dwell_q);
    pcnt_d     = pcnt_q + 1'b1;
    pwm_d      = (duty_q == MAX) | (pcnt_q < duty_q);

    // Run withdrawal / reassertion always beats a coincident step.
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RAMP_UP;
          duty_d  = sat_add('0);
          fast_d  = rapido;
        end
      end
      RAMP_UP: begin
        if (!run) begin
          state_d = RAMP_DOWN;
        end else if (step) begin
          duty_d = sat_add(duty_q);
          if (duty_d == MAX) state_d = FULL;
        end
      end
      FULL: begin
        duty_d = MAX;
        if (!run) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (run) begin
          state_d = RAMP_UP;
          fast_d  = rapido;
        end else if (step) begin
          duty_d = sat_sub(duty_q);
          if (duty_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Restarting both counters on entry makes step timing relative to the state change.
    if (state_d != state_q) begin
      presc_d = '0;
      dwell_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      pcnt_q  <= '0;
      presc_q <= '0;
      dwell_q <= '0;
      fast_q  <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pcnt_q  <= pcnt_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      fast_q  <= fast_d;
      pwm_q   <= pwm_d;
    end
  end

  assign duty    = duty_q;
  assign pwm_out = pwm_q;
  assign state   = state_q;
  assign running = (state_q != IDLE);
  assign at_full = (state_q == FULL);

endmodule

// File: tb/tb_soft_start_ramp_pwm.sv
// Scoreboard bench for soft_start_ramp_pwm: directed sequences plus random run
// requests, checked every cycle against a time-since-entry reference model.
module tb_soft_start_ramp_pwm;

  localparam int MAXV  = 255;
  localparam int STEPV = 64;
  localparam int TDIV  = 4;
  localparam int DF    = 2;
  localparam int DS    = 5;

  logic       clk = 1'b0;
  logic       reset, rapido, lento;
  logic [7:0] duty;
  logic       pwm_out;
  logic [1:0] state;
  logic       running, at_full;

  always #5 clk = ~clk;

  soft_start_ramp_pwm #(
    .WIDTH(8), .DUTY_STEP(STEPV), .TICK_DIV(TDIV), .DWELL_FAST(DF), .DWELL_SLOW(DS)
  ) dut (
    .clk(clk), .reset(reset), .rapido(rapido), .lento(lento),
    .duty(duty), .pwm_out(pwm_out), .state(state),
    .running(running), .at_full(at_full)
  );

  typedef struct {
    int duty;
    bit pwm;
    int st;
    bit running;
    bit at_full;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: steps happen every dwell*TICK_DIV clocks after state entry.
  int m_state = 0, m_duty = 0, m_age = 0, m_pcnt = 0;
  bit m_fast = 1'b0, m_pwm = 1'b0;

  task automatic model_edge(input bit r, input bit rap, input bit len);
    int period, age_n, nxt;
    bit run, stp;
    if (r) begin
      m_state = 0; m_duty = 0; m_age = 0; m_pcnt = 0; m_fast = 1'b0; m_pwm = 1'b0;
      return;
    end
    m_pwm  = (m_duty == MAXV) || (m_pcnt < m_duty);
    m_pcnt = (m_pcnt + 1) % 256;
    run    = rap | len;
    period = (m_fast ? DF : DS) * TDIV;
    age_n  = m_age + 1;
    stp    = (age_n % period) == 0;
    nxt    = m_state;
    case (m_state)
      0: if (run) begin
           nxt = 1;
           m_duty = (STEPV < MAXV) ? STEPV : MAXV;
           m_fast = rap;
         end
      1: if (!run) nxt = 3;
         else if (stp) begin
           m_duty = (m_duty + STEPV > MAXV) ? MAXV : m_duty + STEPV;
           if (m_duty == MAXV) nxt = 2;
         end
      2: begin
           m_duty = MAXV;
           if (!run) nxt = 3;
         end
      default: if (run) begin
           nxt = 1;
           m_fast = rap;
         end else if (stp) begin
           m_duty = (m_duty - STEPV < 0) ? 0 : m_duty - STEPV;
           if (m_duty == 0) nxt = 0;
         end
    endcase
    m_age   = (nxt != m_state) ? 0 : age_n;
    m_state = nxt;
  endtask

  task automatic apply(input bit r, input bit rap, input bit len, input int n);
    exp_t e;
    repeat (n) begin
      reset = r; rapido = rap; lento = len;
      model_edge(r, rap, len);
      e.duty = m_duty; e.pwm = m_pwm; e.st = m_state;
      e.running = (m_state != 0); e.at_full = (m_state == 2);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      vectors++;
      if (duty !== 8'(mon_e.duty)) begin
        miscompares++;
        $display("FAIL duty t=%0t got=%0d want=%0d", $time, duty, mon_e.duty);
      end
      if (pwm_out !== mon_e.pwm) begin
        miscompares++;
        $display("FAIL pwm_out t=%0t got=%b want=%b", $time, pwm_out, mon_e.pwm);
      end
      if (state !== 2'(mon_e.st)) begin
        miscompares++;
        $display("FAIL state t=%0t got=%0d want=%0d", $time, state, mon_e.st);
      end
      if (running !== mon_e.running) begin
        miscompares++;
        $display("FAIL running t=%0t got=%b want=%b", $time, running, mon_e.running);
      end
      if (at_full !== mon_e.at_full) begin
        miscompares++;
        $display("FAIL at_full t=%0t got=%b want=%b", $time, at_full, mon_e.at_full);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rapido = 1'b0; lento = 1'b0;
    apply(1, 0, 0, 2);

    // Fast ramp to FULL, hold, then ramp down to IDLE.
    apply(0, 1, 0, 40);
    apply(0, 0, 0, 40);
    apply(0, 0, 0, 10);

    // Slow ramp and stop.
    apply(1, 0, 0, 1);
    apply(0, 0, 1, 61);
    apply(0, 0, 0, 90);

    // Reverse mid-ramp: fast to 128, drop, reassert slow, later rapido too.
    apply(1, 0, 0, 1);
    apply(0, 1, 0, 9);
    apply(0, 0, 0, 5);
    apply(0, 0, 1, 10);
    apply(0, 1, 1, 60);
    apply(0, 0, 0, 90);

    // PWM windows at FULL and in IDLE.
    apply(1, 0, 0, 1);
    apply(0, 1, 0, 300);
    apply(0, 0, 0, 40);
    apply(0, 0, 0, 260);

    // Both requests -> fast; drop run on the step edge.
    apply(1, 0, 0, 1);
    apply(0, 1, 1, 8);
    apply(0, 0, 0, 40);

    // Reset mid-ramp at 192 with run still high.
    apply(1, 0, 0, 1);
    apply(0, 1, 0, 17);
    apply(1, 1, 0, 1);
    apply(0, 1, 0, 12);

    // Randomized run requests, durations and occasional resets.
    for (int i = 0; i < 150; i++) begin
      bit r, a, b;
      int n;
      r = ($urandom_range(0, 19) == 0);
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      n = r ? $urandom_range(1, 2) : $urandom_range(1, 70);
      apply(r, a, b, n);
    end

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
